// File: rtl/enc4to2_scan_pkg.sv
// Shared types and widths for the sequential 4-to-2 scan encoder.
package enc_pkg;

   localparam int IN_W   = 4;
   localparam int CODE_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } encStateT;

endpackage

// File: rtl/enc4to2_scan_prio_enc4.sv
// Combinational set-bit finder: lowest or highest set index of a 4-bit vector.
module prio_enc4
   import enc_pkg::*;
(
   input  logic [IN_W-1:0]   vec,
   input  logic              lsbFirst,
   output logic [CODE_W-1:0] idx,
   output logic              any
);

   logic [CODE_W-1:0] lowIdx;
   logic [CODE_W-1:0] highIdx;

   // Lowest set bit
   always_comb begin
      lowIdx = 2'd0;
      casez (vec)
         4'b???1: lowIdx = 2'd0;
         4'b??10: lowIdx = 2'd1;
         4'b?100: lowIdx = 2'd2;
         4'b1000: lowIdx = 2'd3;
         default: lowIdx = 2'd0;
      endcase
   end

   // Highest set bit
   always_comb begin
      highIdx = 2'd0;
      casez (vec)
         4'b1???: highIdx = 2'd3;
         4'b01??: highIdx = 2'd2;
         4'b001?: highIdx = 2'd1;
         4'b0001: highIdx = 2'd0;
         default: highIdx = 2'd0;
      endcase
   end

   // Direction select and any-set flag
   always_comb begin
      any = |vec;
      if (lsbFirst) begin
         idx = lowIdx;
      end else begin
         idx = highIdx;
      end
   end

endmodule

// File: rtl/enc4to2_scan.sv
// Sequential 4-to-2 encoder: captures a request vector on load and emits the
// code of every active bit, one per valid/ready handshake.
module enc4to2_scan
   import enc_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1,
   parameter int IN_W      = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_W-1:0]   i,
   input  logic              pol,
   input  logic              load,
   input  logic              ready,
   output logic [CODE_W-1:0] o,
   output logic              valid,
   output logic              busy,
   output logic              done,
   output logic              none
);

   encStateT          state;
   encStateT          stateNext;
   logic [IN_W-1:0]   pending;
   logic [IN_W-1:0]   pendingNext;
   logic [IN_W-1:0]   captured;
   logic [IN_W-1:0]   afterAccept;
   logic [IN_W-1:0]   scanVec;
   logic [CODE_W-1:0] oNext;
   logic [CODE_W-1:0] nextIdx;
   logic              nextAny;
   logic              validNext;
   logic              busyNext;
   logic              doneNext;
   logic              noneNext;
   logic              handshake;

   assign captured    = i ^ {IN_W{pol}};
   assign handshake   = valid & ready;
   // o always names a set bit of pending while scanning, so clearing it retires that code
   assign afterAccept = pending & ~({{(IN_W-1){1'b0}}, 1'b1} << o);

   // Vector the finder looks at: fresh capture when idle, post-clear value when scanning
   always_comb begin
      scanVec = pending;
      if (state == IDLE) begin
         scanVec = captured;
      end else begin
         scanVec = afterAccept;
      end
   end

   prio_enc4 uPrio (
      .vec      (scanVec),
      .lsbFirst (LSB_FIRST),
      .idx      (nextIdx),
      .any      (nextAny)
   );

   // Next-state and next-output logic
   always_comb begin
      stateNext   = state;
      pendingNext = pending;
      oNext       = o;
      validNext   = valid;
      busyNext    = busy;
      doneNext    = 1'b0;
      noneNext    = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               pendingNext = captured;
               if (nextAny) begin
                  stateNext = SCAN;
                  oNext     = nextIdx;
                  validNext = 1'b1;
                  busyNext  = 1'b1;
               end else begin
                  noneNext  = 1'b1;
               end
            end else begin
               pendingNext = pending;
            end
         end
         SCAN: begin
            if (handshake) begin
               pendingNext = afterAccept;
               if (nextAny) begin
                  oNext     = nextIdx;
               end else begin
                  stateNext = IDLE;
                  validNext = 1'b0;
                  busyNext  = 1'b0;
                  doneNext  = 1'b1;
               end
            end else begin
               oNext = o;
            end
         end
         default: begin
            stateNext   = IDLE;
            pendingNext = {IN_W{1'b0}};
            validNext   = 1'b0;
            busyNext    = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pending <= {IN_W{1'b0}};
         o       <= {CODE_W{1'b0}};
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         none    <= 1'b0;
      end else begin
         state   <= stateNext;
         pending <= pendingNext;
         o       <= oNext;
         valid   <= validNext;
         busy    <= busyNext;
         done    <= doneNext;
         none    <= noneNext;
      end
   end

endmodule

// File: tb/tb_enc4to2_scan.sv
// Self-checking bench: two encoders (lowest-first and highest-first) share stimulus
// and are compared against a set-bit ordering model and an ideal one-hot decoder.
module tb_enc4to2_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] i = 4'd0;
   logic       pol = 1'b0;
   logic       load = 1'b0;
   logic       ready = 1'b0;
   logic [1:0] oL, oM;
   logic       validL, busyL, doneL, noneL;
   logic       validM, busyM, doneM, noneM;
   int         checks = 0;
   int         passes = 0;

   always #5 clk = ~clk;

   enc4to2_scan #(.LSB_FIRST(1'b1), .IN_W(4)) dutL (
      .clk(clk), .rst(rst), .i(i), .pol(pol), .load(load), .ready(ready),
      .o(oL), .valid(validL), .busy(busyL), .done(doneL), .none(noneL)
   );

   enc4to2_scan #(.LSB_FIRST(1'b0), .IN_W(4)) dutM (
      .clk(clk), .rst(rst), .i(i), .pol(pol), .load(load), .ready(ready),
      .o(oM), .valid(validM), .busy(busyM), .done(doneM), .none(noneM)
   );

   // Model: indices of the set bits, in ascending or descending order
   task automatic expectedCodes(input logic [3:0] p, input bit lsb,
                                output logic [1:0] seq [4], output int n);
      n = 0;
      for (int k = 0; k < 4; k++) seq[k] = 2'd0;
      for (int k = 0; k < 4; k++) begin
         int b;
         b = lsb ? k : 3 - k;
         if (p[b]) begin
            seq[n] = 2'(b);
            n++;
         end
      end
   endtask

   // One-cycle load pulse; returns in the cycle after the capturing edge
   task automatic doLoad(input logic [3:0] iv, input logic pv);
      @(negedge clk);
      i = iv; pol = pv; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if ({oL, validL, busyL, doneL, noneL} !== 6'd0) $display("FAIL reset_L got %b want 000000", {oL, validL, busyL, doneL, noneL}); else passes++;
      checks++; if ({oM, validM, busyM, doneM, noneM} !== 6'd0) $display("FAIL reset_M got %b want 000000", {oM, validM, busyM, doneM, noneM}); else passes++;
      rst = 1'b0;
   endtask

   task automatic test_lsb_order();
      logic [1:0] seq [4];
      int n, busyCnt;
      ready = 1'b1;
      expectedCodes(4'b1011, 1'b1, seq, n);
      doLoad(4'b1011, 1'b0);
      busyCnt = 0;
      for (int k = 0; k < n; k++) begin
         checks++; if (validL !== 1'b1 || oL !== seq[k]) $display("FAIL lsb_code%0d got v=%b o=%0d want v=1 o=%0d", k, validL, oL, seq[k]); else passes++;
         if (busyL) busyCnt++;
         @(negedge clk);
      end
      checks++; if ({doneL, validL, busyL} !== 3'b100) $display("FAIL lsb_done got d/v/b=%b want 100", {doneL, validL, busyL}); else passes++;
      checks++; if (busyCnt !== 3) $display("FAIL lsb_busy_len got %0d want 3", busyCnt); else passes++;
      @(negedge clk);
      checks++; if (doneL !== 1'b0) $display("FAIL lsb_done_pulse got %b want 0", doneL); else passes++;
   endtask

   task automatic test_msb_order();
      logic [1:0] seq [4];
      int n;
      ready = 1'b1;
      expectedCodes(4'b1011, 1'b0, seq, n);
      doLoad(4'b1011, 1'b0);
      for (int k = 0; k < n; k++) begin
         checks++; if (validM !== 1'b1 || oM !== seq[k]) $display("FAIL msb_code%0d got v=%b o=%0d want v=1 o=%0d", k, validM, oM, seq[k]); else passes++;
         @(negedge clk);
      end
      checks++; if ({doneM, validM, busyM} !== 3'b100) $display("FAIL msb_done got d/v/b=%b want 100", {doneM, validM, busyM}); else passes++;
      @(negedge clk);
      checks++; if (doneM !== 1'b0) $display("FAIL msb_done_pulse got %b want 0", doneM); else passes++;
   endtask

   task automatic test_none_and_single();
      ready = 1'b1;
      doLoad(4'b1111, 1'b1);
      checks++; if ({noneL, validL, busyL} !== 3'b100) $display("FAIL none_L got n/v/b=%b want 100", {noneL, validL, busyL}); else passes++;
      checks++; if ({noneM, validM, busyM} !== 3'b100) $display("FAIL none_M got n/v/b=%b want 100", {noneM, validM, busyM}); else passes++;
      @(negedge clk);
      checks++; if ({noneL, validL, busyL, doneL} !== 4'b0000) $display("FAIL none_pulse got n/v/b/d=%b want 0000", {noneL, validL, busyL, doneL}); else passes++;
      doLoad(4'b1101, 1'b1);
      checks++; if (validL !== 1'b1 || oL !== 2'd1 || validM !== 1'b1 || oM !== 2'd1) $display("FAIL single_code got oL=%0d oM=%0d want 1 1", oL, oM); else passes++;
      @(negedge clk);
      checks++; if ({doneL, validL, doneM, validM} !== 4'b1010) $display("FAIL single_done got %b want 1010", {doneL, validL, doneM, validM}); else passes++;
   endtask

   task automatic test_stall();
      ready = 1'b0;
      doLoad(4'b0110, 1'b0);
      for (int s = 0; s < 4; s++) begin
         checks++; if (validL !== 1'b1 || oL !== 2'd1 || validM !== 1'b1 || oM !== 2'd2) $display("FAIL stall%0d got oL=%0d vL=%b oM=%0d vM=%b want 1 1 2 1", s, oL, validL, oM, validM); else passes++;
         if (s == 1) begin
            i = 4'b1000; load = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      ready = 1'b1;
      checks++; if (oL !== 2'd1 || validL !== 1'b1) $display("FAIL stall_release got o=%0d v=%b want 1 1", oL, validL); else passes++;
      @(negedge clk);
      checks++; if (oL !== 2'd2 || validL !== 1'b1 || oM !== 2'd1) $display("FAIL stall_second got oL=%0d oM=%0d want 2 1", oL, oM); else passes++;
      @(negedge clk);
      checks++; if ({doneL, validL, doneM, validM} !== 4'b1010) $display("FAIL stall_done got %b want 1010", {doneL, validL, doneM, validM}); else passes++;
      @(negedge clk);
      checks++; if ({validL, busyL, validM, busyM} !== 4'b0000) $display("FAIL stall_ignored_load got %b want 0000", {validL, busyL, validM, busyM}); else passes++;
   endtask

   task automatic test_async_reset();
      ready = 1'b1;
      doLoad(4'b1111, 1'b0);
      @(negedge clk);
      checks++; if (oL !== 2'd1 || validL !== 1'b1) $display("FAIL arst_pre got o=%0d v=%b want 1 1", oL, validL); else passes++;
      #2 rst = 1'b1;
      #1;
      checks++; if ({oL, validL, busyL, doneL} !== 5'd0 || {oM, validM, busyM, doneM} !== 5'd0) $display("FAIL arst_immediate got L=%b M=%b want 0", {oL, validL, busyL, doneL}, {oM, validM, busyM, doneM}); else passes++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({doneL, validL, doneM, validM} !== 4'b0000) $display("FAIL arst_no_done got %b want 0000", {doneL, validL, doneM, validM}); else passes++;
      doLoad(4'b0101, 1'b0);
      checks++; if (oL !== 2'd0 || validL !== 1'b1 || oM !== 2'd2 || validM !== 1'b1) $display("FAIL arst_restart got oL=%0d oM=%0d want 0 2", oL, oM); else passes++;
      @(negedge clk);
      checks++; if (oL !== 2'd2 || oM !== 2'd0) $display("FAIL arst_restart2 got oL=%0d oM=%0d want 2 0", oL, oM); else passes++;
      @(negedge clk);
      checks++; if ({doneL, doneM} !== 2'b11) $display("FAIL arst_done got %b want 11", {doneL, doneM}); else passes++;
   endtask

   task automatic test_round_trip();
      logic [1:0] seqL [4];
      logic [1:0] seqM [4];
      logic [3:0] pend, orL, orM;
      logic [1:0] heldL, heldM;
      logic       p, holdL, holdM, finished;
      int         nL, nM, idxL, idxM, cyc;
      for (int v = 0; v < 16; v++) begin
         p    = 1'($urandom_range(0, 1));
         pend = 4'(v) ^ {4{p}};
         expectedCodes(pend, 1'b1, seqL, nL);
         expectedCodes(pend, 1'b0, seqM, nM);
         doLoad(4'(v), p);
         if (pend == 4'd0) begin
            checks++; if ({noneL, validL, noneM, validM} !== 4'b1010) $display("FAIL rt_none v=%0d got %b want 1010", v, {noneL, validL, noneM, validM}); else passes++;
            @(negedge clk);
            checks++; if ({noneL, noneM} !== 2'b00) $display("FAIL rt_none_pulse v=%0d got %b want 00", v, {noneL, noneM}); else passes++;
         end else begin
            orL = 4'd0; orM = 4'd0; idxL = 0; idxM = 0;
            holdL = 1'b0; holdM = 1'b0; heldL = 2'd0; heldM = 2'd0;
            finished = 1'b0; cyc = 0;
            while (!finished && cyc < 40) begin
               if (holdL) begin
                  checks++; if (validL !== 1'b1 || oL !== heldL) $display("FAIL rt_hold_L v=%0d got o=%0d v=%b want o=%0d v=1", v, oL, validL, heldL); else passes++;
               end
               if (holdM) begin
                  checks++; if (validM !== 1'b1 || oM !== heldM) $display("FAIL rt_hold_M v=%0d got o=%0d v=%b want o=%0d v=1", v, oM, validM, heldM); else passes++;
               end
               ready = 1'($urandom_range(0, 1));
               holdL = validL && !ready; heldL = oL;
               holdM = validM && !ready; heldM = oM;
               if (validL && ready) begin
                  checks++; if (idxL >= nL || oL !== seqL[idxL % 4]) $display("FAIL rt_code_L v=%0d n=%0d got %0d want %0d", v, idxL, oL, seqL[idxL % 4]); else passes++;
                  orL = orL | (4'b0001 << oL);
                  idxL++;
               end
               if (validM && ready) begin
                  checks++; if (idxM >= nM || oM !== seqM[idxM % 4]) $display("FAIL rt_code_M v=%0d n=%0d got %0d want %0d", v, idxM, oM, seqM[idxM % 4]); else passes++;
                  orM = orM | (4'b0001 << oM);
                  idxM++;
               end
               load = ($urandom_range(0, 3) == 0);
               i    = 4'($urandom);
               pol  = 1'($urandom);
               @(negedge clk);
               cyc++;
               if (doneL) finished = 1'b1;
            end
            load = 1'b0;
            checks++; if (finished !== 1'b1 || doneM !== 1'b1 || validL !== 1'b0 || validM !== 1'b0) $display("FAIL rt_done v=%0d got fin=%b dM=%b vL=%b vM=%b want 1 1 0 0", v, finished, doneM, validL, validM); else passes++;
            checks++; if (idxL !== nL || idxM !== nM) $display("FAIL rt_count v=%0d got %0d/%0d want %0d", v, idxL, idxM, nL); else passes++;
            checks++; if (orL !== pend || orM !== pend) $display("FAIL rt_decode v=%0d got %b/%b want %b", v, orL, orM, pend); else passes++;
            @(negedge clk);
            checks++; if ({doneL, doneM, busyL, busyM} !== 4'b0000) $display("FAIL rt_done_pulse v=%0d got %b want 0000", v, {doneL, doneM, busyL, busyM}); else passes++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_lsb_order();
      test_msb_order();
      test_none_and_single();
      test_stall();
      test_async_reset();
      test_round_trip();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
